rv32m_seq_divider: RTL and testbench



---
 rtl/rv32m_seq_divider_pkg.sv | 20 ++
 rtl/rv32m_seq_divider_restore_step.sv | 27 ++
 rtl/rv32m_seq_divider.sv | 117 +++++++++++
 tb/tb_rv32m_seq_divider.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32m_seq_divider_pkg.sv
// Shared op codes and op-class helpers for the RV32M sequential divider.
// DIV_OP_WIDTH and the DIVop encodings match the core's existing MUL/DIV op table.
package rv32m_seq_divider_pkg;

    localparam int DIV_OP_WIDTH = 2;

    localparam logic [DIV_OP_WIDTH-1:0] OP_DIV  = 2'd0;
    localparam logic [DIV_OP_WIDTH-1:0] OP_DIVU = 2'd1;
    localparam logic [DIV_OP_WIDTH-1:0] OP_REM  = 2'd2;
    localparam logic [DIV_OP_WIDTH-1:0] OP_REMU = 2'd3;

    function automatic logic is_signed_op(input logic [DIV_OP_WIDTH-1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input logic [DIV_OP_WIDTH-1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/rv32m_seq_divider_restore_step.sv
// One radix-2 restoring iteration: shift {rem,q} left, trial-subtract, keep or restore.
// Purely combinational; the top reuses this single instance every CALC cycle.
module div_restore_step (
    input  logic [32:0] rem,
    input  logic [31:0] q,
    input  logic [31:0] divisor,
    output logic [32:0] rem_next,
    output logic [31:0] q_next
);

    logic [33:0] shifted;
    logic [33:0] trial;

    always_comb begin
        shifted = {rem, q[31]};
        trial   = shifted - {2'b00, divisor};
        // A clear sign bit means the trial remainder is non-negative.
        if (!trial[33]) begin
            rem_next = trial[32:0];
            q_next   = {q[30:0], 1'b1};
        end else begin
            rem_next = shifted[32:0];
            q_next   = {q[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/rv32m_seq_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU (one quotient bit per cycle).
// Divide-by-zero and signed overflow bypass the iteration and complete in one cycle.
module rv32m_seq_divider
    import rv32m_seq_divider_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             dividend,
    input  logic [31:0]             divisor,
    input  logic [DIV_OP_WIDTH-1:0] DIVop,
    input  logic                    div_valid,
    output logic                    div_ready,
    output logic [31:0]             div_result,
    output logic                    div_by_zero_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic        rem_op;
    logic        neg_q;
    logic        neg_r;
    logic [32:0] rem;
    logic [31:0] q;
    logic [31:0] dvsr;
    logic [4:0]  cnt;

    logic [32:0] rem_next;
    logic [31:0] q_next;
    logic        signed_req;
    logic        overflow_req;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    div_restore_step u_step (
        .rem      (rem),
        .q        (q),
        .divisor  (dvsr),
        .rem_next (rem_next),
        .q_next   (q_next)
    );

    // 0x80000000 negates to itself, which is already its correct unsigned magnitude.
    always_comb begin
        signed_req   = is_signed_op(DIVop);
        a_mag        = cond_neg(dividend, signed_req & dividend[31]);
        b_mag        = cond_neg(divisor,  signed_req & divisor[31]);
        overflow_req = signed_req && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
    end

    assign div_ready = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            rem_op          <= 1'b0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            rem             <= '0;
            q               <= '0;
            dvsr            <= '0;
            cnt             <= '0;
            div_result      <= '0;
            div_by_zero_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (div_valid) begin
                        rem_op <= is_rem_op(DIVop);
                        neg_q  <= signed_req & (dividend[31] ^ divisor[31]);
                        neg_r  <= signed_req & dividend[31];
                        rem    <= '0;
                        cnt    <= '0;
                        q      <= a_mag;
                        dvsr   <= b_mag;
                        if (divisor == 32'd0) begin
                            div_result      <= is_rem_op(DIVop) ? dividend : 32'hFFFF_FFFF;
                            div_by_zero_err <= 1'b1;
                            state           <= S_DONE;
                        end else if (overflow_req) begin
                            div_result      <= (DIVop == OP_DIV) ? 32'h8000_0000 : 32'd0;
                            div_by_zero_err <= 1'b0;
                            state           <= S_DONE;
                        end else begin
                            div_by_zero_err <= 1'b0;
                            state           <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem <= rem_next;
                    q   <= q_next;
                    cnt <= cnt + 5'd1;
                    // The final iteration's step outputs feed the sign fix-up directly.
                    if (cnt == 5'd31) begin
                        div_result <= rem_op ? cond_neg(rem_next[31:0], neg_r)
                                             : cond_neg(q_next, neg_q);
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32m_seq_divider.sv
// Directed and random scoreboard bench for rv32m_seq_divider.
// Expected results are queued at request time and popped when div_ready pulses.
module tb_rv32m_seq_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [1:0]  DIVop;
    logic        div_valid;
    logic        div_ready;
    logic [31:0] div_result;
    logic        div_by_zero_err;

    typedef struct packed {
        logic [31:0] res;
        logic        err;
        logic [5:0]  lat;
    } exp_t;

    exp_t scoreboard[$];
    int vectors = 0;
    int miscompares = 0;

    rv32m_seq_divider dut (
        .clk             (clk),
        .reset           (reset),
        .dividend        (dividend),
        .divisor         (divisor),
        .DIVop           (DIVop),
        .div_valid       (div_valid),
        .div_ready       (div_ready),
        .div_result      (div_result),
        .div_by_zero_err (div_by_zero_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] res, input logic err, input int lat);
        exp_t e;
        e.res = res;
        e.err = err;
        e.lat = 6'(lat);
        return e;
    endfunction

    // Reference model built on the simulator's own signed/unsigned division.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        sa    = a;
        sbv   = b;
        e.err = 1'b0;
        e.lat = 6'd33;
        if (b == 32'd0) begin
            e.err = 1'b1;
            e.lat = 6'd1;
            e.res = (op == 2'd2 || op == 2'd3) ? a : 32'hFFFF_FFFF;
        end else if ((op == 2'd0 || op == 2'd2) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lat = 6'd1;
            e.res = (op == 2'd0) ? 32'h8000_0000 : 32'd0;
        end else begin
            case (op)
                2'd0:    e.res = sa / sbv;
                2'd1:    e.res = a / b;
                2'd2:    e.res = sa % sbv;
                default: e.res = a % b;
            endcase
        end
        return e;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Ticks until div_ready, bounded; n counts edges taken.
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!div_ready && n < 60);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input exp_t want, input int drop_at,
                          input bit scramble);
        exp_t got_exp;
        int lat;
        scoreboard.push_back(want);
        dividend  = a;
        divisor   = b;
        DIVop     = op;
        div_valid = 1'b1;
        tick();
        lat = 1;
        while (!div_ready && lat < 40) begin
            if (scramble) begin
                dividend = $urandom;
                divisor  = $urandom;
                DIVop    = 2'($urandom);
            end
            if (lat == drop_at) div_valid = 1'b0;
            tick();
            lat++;
        end
        div_valid = 1'b0;
        got_exp = scoreboard.pop_front();
        check({tag, "/lat"}, 32'(lat), 32'(got_exp.lat));
        check({tag, "/res"}, div_result, got_exp.res);
        check({tag, "/err"}, 32'(div_by_zero_err), 32'(got_exp.err));
        tick();
        check({tag, "/pulse"}, 32'(div_ready), 32'd0);
        check({tag, "/hold"}, div_result, got_exp.res);
    endtask

    initial begin
        exp_t e;
        int n;
        int pulses;

        reset     = 1'b1;
        div_valid = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        DIVop     = 2'd0;
        tick();
        tick();
        reset = 1'b0;
        check("rst/ready", 32'(div_ready), 32'd0);
        check("rst/res", div_result, 32'd0);
        check("rst/err", 32'(div_by_zero_err), 32'd0);

        run_op("div100_7",  2'd0, 32'd100, 32'd7, mk(32'h0000_000E, 1'b0, 33), 0, 1'b0);
        run_op("rem100_7",  2'd2, 32'd100, 32'd7, mk(32'd2, 1'b0, 33), 0, 1'b0);
        run_op("divm7_2",   2'd0, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFD, 1'b0, 33), 0, 1'b0);
        run_op("remm7_2",   2'd2, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFF, 1'b0, 33), 0, 1'b0);
        run_op("divu_max",  2'd1, 32'hFFFF_FFFF, 32'd2, mk(32'h7FFF_FFFF, 1'b0, 33), 0, 1'b0);
        run_op("remu_max",  2'd3, 32'hFFFF_FFFF, 32'd2, mk(32'd1, 1'b0, 33), 0, 1'b0);
        run_op("div_by0",   2'd0, 32'd5, 32'd0, mk(32'hFFFF_FFFF, 1'b1, 1), 0, 1'b0);
        run_op("remu_by0",  2'd3, 32'd5, 32'd0, mk(32'd5, 1'b1, 1), 0, 1'b0);
        run_op("div6_3",    2'd0, 32'd6, 32'd3, mk(32'd2, 1'b0, 33), 0, 1'b0);
        run_op("div_ovf",   2'd0, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 1'b0, 1), 0, 1'b0);
        run_op("rem_ovf",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'd0, 1'b0, 1), 0, 1'b0);
        run_op("divu_ovf",  2'd1, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'd0, 1'b0, 33), 0, 1'b0);
        run_op("scramble",  2'd0, 32'd1000, 32'hFFFF_FFFD, mk(32'hFFFF_FEB3, 1'b0, 33), 0, 1'b1);
        run_op("drop_vld",  2'd0, 32'd77, 32'd7, mk(32'd11, 1'b0, 33), 10, 1'b0);

        // Reset in cycle 10 of a DIV aborts it with no completion pulse.
        dividend  = 32'd100;
        divisor   = 32'd7;
        DIVop     = 2'd0;
        div_valid = 1'b1;
        tick();
        for (int i = 1; i < 10; i++) tick();
        reset     = 1'b1;
        div_valid = 1'b0;
        tick();
        reset = 1'b0;
        check("abort/ready", 32'(div_ready), 32'd0);
        check("abort/res", div_result, 32'd0);
        check("abort/err", 32'(div_by_zero_err), 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (div_ready) pulses++;
        end
        check("abort/no_ready", 32'(pulses), 32'd0);
        run_op("after_abort", 2'd1, 32'd50, 32'd5, mk(32'd10, 1'b0, 33), 0, 1'b0);

        // div_valid held across DONE: the next op is accepted in the following IDLE cycle.
        scoreboard.push_back(mk(32'h0000_000E, 1'b0, 33));
        dividend  = 32'd100;
        divisor   = 32'd7;
        DIVop     = 2'd0;
        div_valid = 1'b1;
        wait_ready(n);
        check("b2b1/lat", 32'(n), 32'd33);
        e = scoreboard.pop_front();
        check("b2b1/res", div_result, e.res);
        scoreboard.push_back(mk(32'd2, 1'b0, 33));
        DIVop = 2'd2;
        wait_ready(n);
        div_valid = 1'b0;
        check("b2b2/gap", 32'(n), 32'd34);
        e = scoreboard.pop_front();
        check("b2b2/res", div_result, e.res);
        tick();

        for (int i = 0; i < 1500; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 2'($urandom);
            ra  = pick_operand();
            rb  = pick_operand();
            run_op("rand", rop, ra, rb, model(rop, ra, rb), 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
